// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// No logic; constants, the fetch-buffer entry type and a PC helper.
// Imported by if_fetch_stage and fetch_fifo.
package if_pkg;

  localparam int unsigned IF_WORD_W    = 32;
  localparam logic [31:0] IF_PC_RESET  = 32'h0000_0000;
  localparam logic [31:0] IF_NOP_INSTR = 32'hF000_0000;

  // One buffered fetch: the address it was fetched from and the word returned.
  typedef struct packed {
    logic [IF_WORD_W-1:0] pc;
    logic [IF_WORD_W-1:0] instr;
  } fetch_entry_t;

  // Sequential successor of a word address (wraps at 2^32).
  function automatic logic [IF_WORD_W-1:0] next_pc(input logic [IF_WORD_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries (address + instruction word).
// Latency: a pushed entry is visible at the head on the next cycle.
// No internal backpressure: the producer's credit scheme guarantees room; push+pop on full is legal.
module fetch_fifo
  import if_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  fetch_entry_t       push_dat,
  input  logic               pop,
  output fetch_entry_t       head_dat,
  input  logic               flush,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  // Storage array: written on push only, never reset (contents gated by count).
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: issues in-order imem reads, buffers returns, drives the IF/ID register.
// Latency: grant at t, rvalid at t+1, instruction on the IF/ID outputs at t+2.
// Backpressure: freeze holds IF/ID; requests stop once in-flight + buffered words reach FIFO_DEPTH.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = IF_PC_RESET,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = IF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        Instr_valid
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  // Fetch-side state.
  logic [31:0]      fpc;          // next address to request
  logic [31:0]      rpc;          // address of the next response that will be kept
  logic [CNT_W-1:0] outstanding;  // granted but not yet returned
  logic [CNT_W-1:0] drop;         // returns still owed to a wrong path
  logic [CNT_W-1:0] outstanding_nxt;
  logic [CNT_W-1:0] drop_nxt;

  // IF/ID register.
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        vld_q;
  logic [31:0] out_pc_d;
  logic [31:0] out_instr_d;
  logic        out_vld_d;

  // Fetch buffer interface.
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     rsp_entry;

  logic credit_ok;
  logic grant;
  logic rsp_keep;

  // Every word in flight already owns a buffer slot, so the FIFO can never overflow.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign imem_req  = rst && credit_ok;
  assign imem_addr = fpc;
  assign grant     = imem_req && imem_gnt;

  // A response is kept only if it is not owed to a discarded path and no redirect is happening now.
  assign rsp_keep  = imem_rvalid && (drop == '0) && !branch_taken;
  assign rsp_entry = '{pc: rpc, instr: imem_rdata};

  assign PC          = pc_q;
  assign Instruction = instr_q;
  assign Instr_valid = vld_q;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (rsp_entry),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .flush    (fifo_flush),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // In-flight and wrong-path counters; a redirect turns everything still in flight into drops.
  always_comb begin
    outstanding_nxt = outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid);
    drop_nxt        = drop;
    if (branch_taken) begin
      drop_nxt = outstanding_nxt;
    end else if (imem_rvalid && (drop != '0)) begin
      drop_nxt = drop - CNT_W'(1);
    end
  end

  // IF/ID selection in priority order: redirect, freeze, buffered word, bypass, bubble.
  always_comb begin
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    out_pc_d    = pc_q;
    out_instr_d = instr_q;
    out_vld_d   = vld_q;
    if (branch_taken) begin
      fifo_flush  = 1'b1;
      out_instr_d = NOP_INSTR;
      out_vld_d   = 1'b0;
    end else if (freeze) begin
      fifo_push = rsp_keep;
    end else if (!fifo_empty) begin
      fifo_pop    = 1'b1;
      fifo_push   = rsp_keep;
      out_pc_d    = next_pc(fifo_head.pc);
      out_instr_d = fifo_head.instr;
      out_vld_d   = 1'b1;
    end else if (rsp_keep) begin
      out_pc_d    = next_pc(rpc);
      out_instr_d = imem_rdata;
      out_vld_d   = 1'b1;
    end else begin
      out_instr_d = NOP_INSTR;
      out_vld_d   = 1'b0;
    end
  end

  // Fetch address, response address and in-flight counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fpc         <= PC_RESET;
      rpc         <= PC_RESET;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      drop        <= drop_nxt;
      if (branch_taken) begin
        fpc <= branch_address;
        rpc <= branch_address;
      end else begin
        if (grant)    fpc <= next_pc(fpc);
        if (rsp_keep) rpc <= next_pc(rpc);
      end
    end
  end

  // IF/ID output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      vld_q   <= 1'b0;
    end else begin
      pc_q    <= out_pc_d;
      instr_q <= out_instr_d;
      vld_q   <= out_vld_d;
    end
  end

  // A response with nothing in flight means the memory broke ordering or returned stale data.
  a_rvalid_orphan: assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid |-> (outstanding != '0));

  // The credit scheme must keep the buffer from being pushed while full without a pop.
  a_push_full: assert property (@(posedge clk) disable iff (!rst)
    !(fifo_push && fifo_full && !fifo_pop && !fifo_flush));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: randomized memory and control, queue-based model.
// Memory returns each word equal to its own fetch address, with a chosen latency.
// Outputs are compared against the model on every negedge after the first reset edge.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'hF000_0000;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        Instr_valid;

  if_fetch_stage #(
    .PC_RESET   (32'h0000_0000),
    .FIFO_DEPTH (2),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .PC             (PC),
    .Instruction    (Instruction),
    .Instr_valid    (Instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 0;

  // Stimulus knobs, applied 2 time units after each posedge.
  bit          s_rst = 0;
  bit          s_freeze = 0;
  bit          s_br = 0;
  logic [31:0] s_br_addr = '0;
  bit          s_gnt = 0;
  bit          s_gnt_rand = 0;
  int          lat = 1;

  // Memory: granted fetches waiting to be returned.
  typedef struct { logic [31:0] addr; int due; } mem_t;
  mem_t        memq[$];
  logic        dut_req_l = 0;
  logic [31:0] dut_addr_l = '0;

  // Model: words in flight (dead = owed to a discarded path), buffered words, IF/ID contents.
  typedef struct { logic [31:0] addr; bit dead; } infl_t;
  infl_t       infl[$];
  logic [31:0] bufq[$];
  logic [31:0] m_fpc   = 32'h0;
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_instr = NOP;
  logic        m_vld   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit          req_m;
    bit          grant;
    bit          keep;
    logic [31:0] w;
    logic [31:0] a;
    req_m = rst && (infl.size() + bufq.size() < 2);
    keep  = 0;
    w     = '0;
    if (!rst) begin
      infl.delete();
      bufq.delete();
      m_fpc   = 32'h0;
      m_pc    = 32'h0;
      m_instr = NOP;
      m_vld   = 1'b0;
    end else begin
      if (imem_rvalid && infl.size() > 0) begin
        infl_t h;
        h    = infl.pop_front();
        keep = !h.dead && !branch_taken;
        w    = h.addr;
      end
      grant = req_m && imem_gnt;
      if (branch_taken) begin
        foreach (infl[i]) infl[i].dead = 1;
        if (grant) infl.push_back('{addr: m_fpc, dead: 1});
        bufq.delete();
        m_instr = NOP;
        m_vld   = 1'b0;
        m_fpc   = branch_address;
      end else begin
        if (grant) begin
          infl.push_back('{addr: m_fpc, dead: 0});
          m_fpc = m_fpc + 32'd4;
        end
        if (freeze) begin
          if (keep) bufq.push_back(w);
        end else if (bufq.size() > 0) begin
          a       = bufq.pop_front();
          m_pc    = a + 32'd4;
          m_instr = a;
          m_vld   = 1'b1;
          if (keep) bufq.push_back(w);
        end else if (keep) begin
          m_pc    = w + 32'd4;
          m_instr = w;
          m_vld   = 1'b1;
        end else begin
          m_instr = NOP;
          m_vld   = 1'b0;
        end
      end
    end
  endtask

  task automatic mem_step();
    int due;
    if (!rst) begin
      memq.delete();
    end else begin
      if (imem_rvalid && memq.size() > 0) void'(memq.pop_front());
      if (dut_req_l && imem_gnt) begin
        due = cyc + lat;
        if (memq.size() > 0 && due <= memq[$].due) due = memq[$].due + 1;
        memq.push_back('{addr: dut_addr_l, due: due});
      end
    end
  endtask

  task automatic apply();
    rst            = s_rst;
    freeze         = s_freeze;
    branch_taken   = s_br;
    branch_address = s_br_addr;
    imem_gnt       = s_gnt_rand ? ($urandom_range(0, 3) != 0) : s_gnt;
    if (s_rst && memq.size() > 0 && memq[0].due <= cyc + 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memq[0].addr;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  // One clock: update model and memory at the edge, drive new inputs, latch the DUT request.
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    mem_step();
    #2;
    apply();
    #6;
    dut_req_l  = imem_req;
    dut_addr_l = imem_addr;
  endtask

  task automatic wait_first_valid(input string name, input logic [31:0] exp_pc);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (Instr_valid === 1'b1) begin
        seen = 1;
        chk(name, PC, exp_pc);
      end else begin
        tick();
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no valid instruction, required PC=%h", name, exp_pc);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_req;
      exp_req = rst && (infl.size() + bufq.size() < 2);
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr, m_fpc);
      chk("PC", PC, m_pc);
      chk("Instruction", Instruction, m_instr);
      chk("Instr_valid", {31'b0, Instr_valid}, {31'b0, m_vld});
    end
  end

  initial begin
    rst = 0; freeze = 0; branch_taken = 0; branch_address = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;

    // Reset values.
    repeat (3) tick();
    chk_en = 1;
    chk("rst_PC", PC, 32'h0);
    chk("rst_Instruction", Instruction, NOP);
    chk("rst_Instr_valid", {31'b0, Instr_valid}, 32'h0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'h0);

    // Streaming with a 1-cycle memory: first word 0 appears two edges after its grant.
    s_rst = 1; s_gnt = 1; lat = 1;
    tick();
    chk("first_req_addr", imem_addr, 32'h0);
    tick();
    tick();
    chk("first_PC", PC, 32'h4);
    chk("first_Instruction", Instruction, 32'h0);
    chk("first_Instr_valid", {31'b0, Instr_valid}, 32'h1);
    repeat (4) tick();

    // Freeze three cycles mid-stream: credit runs out, outputs hold.
    s_freeze = 1;
    tick();
    tick();
    chk("freeze_req_off", {31'b0, imem_req}, 32'h0);
    chk("freeze_valid_held", {31'b0, Instr_valid}, 32'h1);
    tick();
    s_freeze = 0;
    repeat (8) tick();

    // Latency-3 memory: bubbles between words.
    lat = 3;
    repeat (12) tick();

    // Redirect with words in flight and one buffered.
    s_freeze = 1;
    repeat (2) tick();
    s_freeze = 0; s_br = 1; s_br_addr = 32'h0000_0100;
    tick();
    s_br = 0;
    tick();
    chk("br_bubble_instr", Instruction, NOP);
    chk("br_bubble_valid", {31'b0, Instr_valid}, 32'h0);
    wait_first_valid("br_first_PC", 32'h0000_0104);
    repeat (6) tick();

    // Redirect together with freeze and a same-cycle grant.
    lat = 1;
    repeat (4) tick();
    s_br = 1; s_freeze = 1; s_br_addr = 32'h0000_0200;
    tick();
    s_br = 0; s_freeze = 0;
    tick();
    chk("brfrz_bubble_valid", {31'b0, Instr_valid}, 32'h0);
    chk("brfrz_fetch_addr", imem_addr, 32'h0000_0200);
    wait_first_valid("brfrz_first_PC", 32'h0000_0204);
    repeat (4) tick();

    // Reset with fetches in flight.
    lat = 3;
    repeat (5) tick();
    s_rst = 0;
    tick();
    tick();
    chk("midrst_PC", PC, 32'h0);
    chk("midrst_Instruction", Instruction, NOP);
    chk("midrst_Instr_valid", {31'b0, Instr_valid}, 32'h0);
    s_rst = 1;
    tick();
    wait_first_valid("midrst_first_PC", 32'h0000_0004);

    // Randomized traffic, including address wrap and occasional reset.
    s_gnt_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      lat       = int'($urandom_range(1, 4));
      s_freeze  = ($urandom_range(0, 3) == 0);
      s_br      = ($urandom_range(0, 15) == 0);
      s_br_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      s_rst     = ($urandom_range(0, 99) != 0);
      tick();
    end
    s_freeze = 0; s_br = 0; s_rst = 1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
